// File: rtl/tcb_pkg.sv
// Shared TCB arbitration types and the round-robin pick helper used by tcb_arb.
package tcb_pkg;

    localparam int TCB_ARB_MAX_IFN = 16;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        HOLD = 2'd1,
        LOCK = 2'd2
    } tcb_arb_state_t;

    // Circular first-set search starting at ptr over the low n bits of vld.
    // With nothing valid the pointer itself is returned, so the idle grant
    // index follows the rotation pointer.
    function automatic logic [3:0] tcb_rr_pick(
        input logic [TCB_ARB_MAX_IFN-1:0] vld,
        input logic [3:0]                 ptr,
        input int                         n
    );
        logic [3:0] idx;
        logic       found;
        tcb_rr_pick = ptr;
        found       = 1'b0;
        for (int k = 0; k < TCB_ARB_MAX_IFN; k++) begin
            idx = 4'((int'(ptr) + k) % n);
            if (!found && (k < n) && vld[idx]) begin
                tcb_rr_pick = idx;
                found       = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/tcb_arb_rsp_pipe.sv
// DLY-stage one-hot tracker: remembers which requester owns each in-flight
// response so strobes return to the right originator.
module tcb_arb_rsp_pipe #(
    parameter int IFN = 2,
    parameter int DLY = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IFN-1:0] i_xfer_oh,
    output logic [IFN-1:0] o_rsp_vld
);

    generate
        if (DLY == 0) begin : g_comb
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;
            assign o_rsp_vld = i_xfer_oh;
        end else begin : g_pipe
            logic [IFN-1:0] r_stage [DLY];

            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples its predecessor's old value on the same edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < DLY; k++) r_stage[k] <= '0;
                end else begin
                    r_stage[0] <= i_xfer_oh;
                    for (int k = 1; k < DLY; k++) r_stage[k] <= r_stage[k-1];
                end
            end

            assign o_rsp_vld = r_stage[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/tcb_arb.sv
// Round-robin TCB arbiter sharing one manager port between IFN requesters.
// Define TCB_ARB_LCK_EN to build the LOCK state and honour sub_lck.
module tcb_arb
    import tcb_pkg::*;
#(
    parameter int IFN = 2,
    parameter int DLY = 1,
    parameter int RQW = 72,
    parameter int RSW = 33,
    localparam int SW = (IFN > 1) ? $clog2(IFN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IFN-1:0]     sub_vld,
    input  logic [IFN-1:0]     sub_lck,
    input  logic [IFN*RQW-1:0] sub_req,
    output logic [IFN-1:0]     sub_rdy,
    output logic [IFN-1:0]     sub_rsp_vld,
    output logic [RSW-1:0]     sub_rsp,
    output logic               man_vld,
    output logic [RQW-1:0]     man_req,
    input  logic               man_rdy,
    input  logic [RSW-1:0]     man_rsp,
    output logic [SW-1:0]      man_sel
);

    tcb_arb_state_t r_state, w_state_nxt;
    logic [SW-1:0]  r_gnt, r_ptr;
    logic [SW-1:0]  w_gnt, w_pick, w_ptr_inc, w_ptr_nxt;
    logic [3:0]     w_pick_full;
    logic [IFN-1:0] w_gnt_oh;
    logic           w_granted, w_xfer, w_lck;

    assign w_pick_full = tcb_rr_pick(16'(sub_vld), 4'(r_ptr), IFN);
    assign w_pick      = w_pick_full[SW-1:0];

    // Zero-latency arbitration in ARB; the grant is frozen once a request is
    // stalled or the bus is locked.
    assign w_gnt     = (r_state == ARB) ? w_pick : r_gnt;
    assign w_granted = (r_state != ARB) || (|sub_vld);
    assign w_gnt_oh  = IFN'(1) << w_gnt;
    assign w_ptr_inc = (w_gnt == SW'(IFN-1)) ? '0 : w_gnt + 1'b1;

    assign man_vld = w_granted & sub_vld[w_gnt];
    assign man_req = sub_req[w_gnt*RQW +: RQW];
    assign man_sel = w_gnt;
    assign sub_rdy = (w_granted & man_rdy) ? w_gnt_oh : '0;
    assign sub_rsp = man_rsp;
    assign w_xfer  = man_vld & man_rdy;

`ifdef TCB_ARB_LCK_EN
    assign w_lck = sub_lck[w_gnt];
`else
    logic w_unused_lck;
    assign w_unused_lck = ^sub_lck;
    assign w_lck        = 1'b0;
`endif

    // NOTE: defaults come first so no path through the case leaves a
    // variable unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ARB: begin
                if (w_xfer) begin
`ifdef TCB_ARB_LCK_EN
                    if (w_lck) w_state_nxt = LOCK;
                    else       w_ptr_nxt   = w_ptr_inc;
`else
                    w_ptr_nxt = w_ptr_inc;
`endif
                end else if (man_vld) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_xfer) begin
                    if (w_lck) begin
                        w_state_nxt = LOCK;
                    end else begin
                        w_state_nxt = ARB;
                        w_ptr_nxt   = w_ptr_inc;
                    end
                end
            end
`ifdef TCB_ARB_LCK_EN
            LOCK: begin
                if (w_xfer && !w_lck) begin
                    w_state_nxt = ARB;
                    w_ptr_nxt   = w_ptr_inc;
                end
            end
`endif
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    tcb_arb_rsp_pipe #(
        .IFN (IFN),
        .DLY (DLY)
    ) u_rsp_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_xfer_oh (w_gnt_oh & {IFN{w_xfer}}),
        .o_rsp_vld (sub_rsp_vld)
    );

endmodule

// File: tb/tb_tcb_arb.sv
// Self-checking bench for tcb_arb: directed scenarios plus random traffic,
// compared against a transaction-level arbitration model and a response queue.
module tb_tcb_arb;

    localparam int IFN = 3;
    localparam int DLY = 2;
    localparam int RQW = 72;
    localparam int RSW = 33;
    localparam int SW  = $clog2(IFN);
`ifdef TCB_ARB_LCK_EN
    localparam bit LCK_EN = 1'b1;
`else
    localparam bit LCK_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [IFN-1:0]     sub_vld = '0;
    logic [IFN-1:0]     sub_lck = '0;
    logic [IFN*RQW-1:0] sub_req = '0;
    logic [IFN-1:0]     sub_rdy;
    logic [IFN-1:0]     sub_rsp_vld;
    logic [RSW-1:0]     sub_rsp;
    logic               man_vld;
    logic [RQW-1:0]     man_req;
    logic               man_rdy = 1'b0;
    logic [RSW-1:0]     man_rsp = '0;
    logic [SW-1:0]      man_sel;

    tcb_arb #(.IFN(IFN), .DLY(DLY), .RQW(RQW), .RSW(RSW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sub_vld     (sub_vld),
        .sub_lck     (sub_lck),
        .sub_req     (sub_req),
        .sub_rdy     (sub_rdy),
        .sub_rsp_vld (sub_rsp_vld),
        .sub_rsp     (sub_rsp),
        .man_vld     (man_vld),
        .man_req     (man_req),
        .man_rdy     (man_rdy),
        .man_rsp     (man_rsp),
        .man_sel     (man_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             due;
        logic [IFN-1:0] oh;
    } rsp_t;

    rsp_t           q[$];
    int             n_chk  = 0;
    int             n_fail = 0;
    int             cyc    = 0;

    // Reference model: rotation pointer plus an optional owner that keeps the
    // bus (stalled request or lock), and per-requester protocol bookkeeping.
    int             m_ptr   = 0;
    int             m_owner = -1;
    logic [IFN-1:0] pend    = '0;
    logic [IFN-1:0] d_vld   = '0;
    logic [IFN-1:0] d_lck   = '0;
    logic [RQW-1:0] d_pay [IFN];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [RQW-1:0] rnd_pay();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[RQW-1:0];
    endfunction

    function automatic logic [RSW-1:0] rnd_rsp();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[RSW-1:0];
    endfunction

    // One bus cycle: apply inputs (pending requesters keep their request),
    // compare combinational outputs with the model, then advance the model.
    task automatic step(input logic [IFN-1:0] want_vld, input logic [IFN-1:0] want_lck,
                        input logic mrdy, input logic rst_in);
        int             g;
        bit             granted, exp_vld, xfer, lck_eff;
        logic [IFN-1:0] oh;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < IFN; i++) begin
            if (!pend[i]) begin
                d_vld[i] = want_vld[i];
                d_lck[i] = want_lck[i];
                d_pay[i] = rnd_pay();
            end
            sub_req[i*RQW +: RQW] = d_pay[i];
        end
        sub_vld = d_vld;
        sub_lck = d_lck;
        man_rdy = mrdy;
        man_rsp = rnd_rsp();
        rst     = rst_in;
        #1;
        g = 0;
        granted = 1'b0;
        if (m_owner >= 0) begin
            g = m_owner;
            granted = 1'b1;
        end else begin
            for (int k = 0; k < IFN; k++) begin
                if (!granted && d_vld[(m_ptr + k) % IFN]) begin
                    g = (m_ptr + k) % IFN;
                    granted = 1'b1;
                end
            end
        end
        exp_vld = granted && d_vld[g];
        xfer    = exp_vld && mrdy;
        oh      = '0;
        oh[g]   = 1'b1;
        check("man_vld", 128'(man_vld), 128'(exp_vld));
        check("sub_rdy", 128'(sub_rdy), (granted && mrdy) ? 128'(oh) : 128'(0));
        if (granted) check("man_sel", 128'(man_sel), 128'(g));
        if (exp_vld) check("man_req", 128'(man_req), 128'(d_pay[g]));
        if (xfer && (!rst_in || DLY == 0)) q.push_back('{due: cyc + DLY, oh: oh});
        if (xfer) pend[g] = 1'b0;
        for (int i = 0; i < IFN; i++)
            if (d_vld[i] && !(xfer && i == g)) pend[i] = 1'b1;
        if (rst_in) begin
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
            m_ptr   = 0;
            m_owner = -1;
        end else if (xfer) begin
            lck_eff = LCK_EN && d_lck[g];
            if (lck_eff) begin
                m_owner = g;
            end else begin
                m_owner = -1;
                m_ptr   = (g + 1) % IFN;
            end
        end else if (exp_vld) begin
            m_owner = g;
        end
    endtask

    // Response monitor: one strobe per tracked transfer, exactly DLY cycles on.
    initial begin
        rsp_t           head;
        logic [IFN-1:0] exp_oh;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                exp_oh = '0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    head   = q.pop_front();
                    exp_oh = head.oh;
                end
                check("sub_rsp_vld", 128'(sub_rsp_vld), 128'(exp_oh));
                check("sub_rsp", 128'(sub_rsp), 128'(man_rsp));
            end
        end
    end

    initial begin
        for (int i = 0; i < IFN; i++) d_pay[i] = '0;

        // Reset release with idle inputs.
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b0);
        check("reset_man_sel", 128'(man_sel), 128'(0));
        check("reset_rsp_vld", 128'(sub_rsp_vld), 128'(0));

        // Full contention: strict rotation including the IFN-1 -> 0 wrap.
        for (int n = 0; n < 7; n++) step('1, '0, 1'b1, 1'b0);

        // Stall hold: requester 1 alone and stalled, requester 0 joins.
        step('0, '0, 1'b1, 1'b1);
        step(3'b010, '0, 1'b0, 1'b0);
        step(3'b011, '0, 1'b0, 1'b0);
        step(3'b011, '0, 1'b0, 1'b0);
        step(3'b011, '0, 1'b1, 1'b0);
        step(3'b001, '0, 1'b1, 1'b0);

        // Lock sequence from requester 0 with requester 1 waiting.
        step('0, '0, 1'b1, 1'b1);
        step(3'b011, 3'b001, 1'b1, 1'b0);
        step(3'b011, 3'b001, 1'b1, 1'b0);
        step(3'b011, 3'b000, 1'b1, 1'b0);
        step(3'b010, 3'b000, 1'b1, 1'b0);

        // Lock owner goes idle, then stalls inside the lock, then releases.
        step('0, '0, 1'b1, 1'b1);
        step(3'b011, 3'b001, 1'b1, 1'b0);
        step(3'b010, 3'b000, 1'b1, 1'b0);
        step(3'b010, 3'b000, 1'b1, 1'b0);
        step(3'b011, 3'b001, 1'b0, 1'b0);
        step(3'b011, 3'b001, 1'b0, 1'b0);
        step(3'b011, 3'b001, 1'b1, 1'b0);
        step(3'b011, 3'b000, 1'b1, 1'b0);
        step(3'b010, 3'b000, 1'b1, 1'b0);

        // Reset inside a lock with a response still in flight.
        step('0, '0, 1'b1, 1'b1);
        step(3'b001, 3'b001, 1'b1, 1'b0);
        step(3'b110, 3'b000, 1'b0, 1'b1);
        step(3'b110, 3'b000, 1'b1, 1'b0);
        step(3'b110, 3'b000, 1'b1, 1'b0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++)
            step(IFN'($urandom), IFN'($urandom & $urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);

        // Drain: keep the bus ready until every requester is served.
        for (int n = 0; n < 40; n++) step('0, '0, 1'b1, 1'b0);
        for (int n = 0; n < DLY + 2; n++) step('0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("rsp_queue_drained", 128'(q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
